// File: rtl/leddc_bank_sched_if.sv
// Host-write and display-side signal bundle for the ping-pong frame-bank scheduler.
// No latency of its own; pure wiring between host/scan logic and the scheduler.
// Backpressure is carried by wr_ready (host side); the display side has none.
interface leddc_bank_sched_if #(
    parameter int IDX_W = 8
);
    logic             wr_en;
    logic             wr_ready;
    logic [IDX_W:0]   wr_addr;
    logic             wr_overflow;
    logic             Vsync;
    logic             rd_valid;
    logic             rd_bank;
    logic             frame_swap;
    logic [7:0]       repeat_cnt;

    modport master (
        output wr_en, Vsync,
        input  wr_ready, wr_addr, wr_overflow, rd_valid, rd_bank, frame_swap, repeat_cnt
    );

    modport slave (
        input  wr_en, Vsync,
        output wr_ready, wr_addr, wr_overflow, rd_valid, rd_bank, frame_swap, repeat_cnt
    );
endinterface

// File: rtl/leddc_bank_sched.sv
// Ping-pong bank scheduler: host fills one 2**IDX_W-word bank (DCK) while the display shows the other (GCK).
// Frame ready -> pend in SYNC_STAGES+1 GCK; release -> wr_ready in about SYNC_STAGES+2 DCK.
// wr_ready drops while both banks are busy; words offered then set sticky wr_overflow. Option: FRAME_REPEAT_CNT_EN.
module leddc_bank_sched #(
    parameter int FRAME_WORDS = 256,
    parameter int IDX_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic DCK,
    input  logic GCK,
    input  logic rst,
    leddc_bank_sched_if.slave bus
);
    typedef enum logic {W_FILL = 1'b0, W_WAIT = 1'b1} wstate_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

    // ---------------- DCK domain ----------------
    wstate_t                state_q, state_d;
    logic                   wr_bank_q, wr_bank_d;
    logic [IDX_W-1:0]       wr_idx_q, wr_idx_d;
    logic [1:0]             busy_q, busy_d, busy_rel;
    logic                   rdy_bank_q, rdy_bank_d;
    logic                   rdy_tgl_q, rdy_tgl_d;
    logic                   wr_ovf_q, wr_ovf_d;
    logic [SYNC_STAGES-1:0] rel_sync_q, rel_sync_d;
    logic                   rel_seen_q, rel_seen_d;
    logic                   wr_ready, accept, last_word, other_free, rel_evt, rel_other;

    // ---------------- GCK domain ----------------
    logic                   vs_q, vs_d;
    logic [SYNC_STAGES-1:0] rdy_sync_q, rdy_sync_d;
    logic                   rdy_seen_q, rdy_seen_d;
    logic                   pend_q, pend_d;
    logic                   pend_bank_q, pend_bank_d;
    logic                   rd_valid_q, rd_valid_d;
    logic                   rd_bank_q, rd_bank_d;
    logic                   swap_q, swap_d;
    logic                   rel_bank_q, rel_bank_d;
    logic                   rel_tgl_q, rel_tgl_d;
    logic                   vs_rise, new_rdy, take_frame;

    // Release events from the display; rel_bank_q is quasi-static by the time the toggle lands
    assign rel_evt   = rel_sync_q[SYNC_STAGES-1] ^ rel_seen_q;
    assign rel_other = rel_evt && (rel_bank_q != wr_bank_q);
    assign accept    = bus.wr_en & wr_ready;
    assign last_word = (wr_idx_q == LAST_IDX);

    // A release landing with the frame-completing word is folded in before the free check
    always_comb begin
        busy_rel = busy_q;
        if (rel_evt) busy_rel[rel_bank_q] = 1'b0;
        other_free = !busy_rel[!wr_bank_q];
    end

    // Write FSM state register
    always_ff @(posedge DCK or posedge rst) begin
        if (rst) state_q <= W_FILL;
        else     state_q <= state_d;
    end

    // Write FSM next state: park when the frame completes with the other bank still busy
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            W_FILL:  if (accept && last_word && !other_free) state_d = W_WAIT;
            W_WAIT:  if (rel_other) state_d = W_FILL;
            default: state_d = W_FILL;
        endcase
    end

    // Write FSM outputs
    always_comb begin
        wr_ready = (state_q == W_FILL);
    end

    // Host datapath: word index, bank selection, busy flags and ready toggle
    always_comb begin
        wr_bank_d  = wr_bank_q;
        wr_idx_d   = wr_idx_q;
        busy_d     = busy_rel;
        rdy_bank_d = rdy_bank_q;
        rdy_tgl_d  = rdy_tgl_q;
        wr_ovf_d   = wr_ovf_q | (bus.wr_en & ~wr_ready);
        rel_sync_d = {rel_sync_q[SYNC_STAGES-2:0], rel_tgl_q};
        rel_seen_d = rel_sync_q[SYNC_STAGES-1];
        if (accept) begin
            if (last_word) begin
                wr_idx_d           = '0;
                busy_d[wr_bank_q]  = 1'b1;
                rdy_bank_d         = wr_bank_q;
                rdy_tgl_d          = ~rdy_tgl_q;
                if (other_free) wr_bank_d = ~wr_bank_q;
            end else begin
                wr_idx_d = wr_idx_q + 1'b1;
            end
        end
        if (state_q == W_WAIT && rel_other) wr_bank_d = ~wr_bank_q;
    end

    // Host-domain registers
    always_ff @(posedge DCK or posedge rst) begin
        if (rst) begin
            wr_bank_q  <= 1'b0;
            wr_idx_q   <= '0;
            busy_q     <= 2'b00;
            rdy_bank_q <= 1'b0;
            rdy_tgl_q  <= 1'b0;
            wr_ovf_q   <= 1'b0;
            rel_sync_q <= '0;
            rel_seen_q <= 1'b0;
        end else begin
            wr_bank_q  <= wr_bank_d;
            wr_idx_q   <= wr_idx_d;
            busy_q     <= busy_d;
            rdy_bank_q <= rdy_bank_d;
            rdy_tgl_q  <= rdy_tgl_d;
            wr_ovf_q   <= wr_ovf_d;
            rel_sync_q <= rel_sync_d;
            rel_seen_q <= rel_seen_d;
        end
    end

    assign vs_rise    = bus.Vsync & ~vs_q;
    assign new_rdy    = rdy_sync_q[SYNC_STAGES-1] ^ rdy_seen_q;
    assign take_frame = vs_rise && (pend_q || new_rdy);

    // Display side: latch ready frames, swap only on Vsync rise, hand the old bank back
    always_comb begin
        vs_d        = bus.Vsync;
        rdy_sync_d  = {rdy_sync_q[SYNC_STAGES-2:0], rdy_tgl_q};
        rdy_seen_d  = rdy_sync_q[SYNC_STAGES-1];
        pend_d      = pend_q;
        pend_bank_d = pend_bank_q;
        rd_valid_d  = rd_valid_q;
        rd_bank_d   = rd_bank_q;
        swap_d      = 1'b0;
        rel_bank_d  = rel_bank_q;
        rel_tgl_d   = rel_tgl_q;
        if (new_rdy) begin
            // A newer frame supersedes an unshown one; the stale bank goes back to the host
            if (pend_q) begin
                rel_bank_d = pend_bank_q;
                rel_tgl_d  = ~rel_tgl_q;
            end
            pend_d      = 1'b1;
            pend_bank_d = rdy_bank_q;
        end
        if (take_frame) begin
            rd_bank_d  = new_rdy ? rdy_bank_q : pend_bank_q;
            rd_valid_d = 1'b1;
            pend_d     = 1'b0;
            swap_d     = 1'b1;
            if (rd_valid_q) begin
                rel_bank_d = rd_bank_q;
                rel_tgl_d  = ~rel_tgl_q;
            end
        end
    end

    // Display-domain registers
    always_ff @(posedge GCK or posedge rst) begin
        if (rst) begin
            vs_q        <= 1'b0;
            rdy_sync_q  <= '0;
            rdy_seen_q  <= 1'b0;
            pend_q      <= 1'b0;
            pend_bank_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_bank_q   <= 1'b0;
            swap_q      <= 1'b0;
            rel_bank_q  <= 1'b0;
            rel_tgl_q   <= 1'b0;
        end else begin
            vs_q        <= vs_d;
            rdy_sync_q  <= rdy_sync_d;
            rdy_seen_q  <= rdy_seen_d;
            pend_q      <= pend_d;
            pend_bank_q <= pend_bank_d;
            rd_valid_q  <= rd_valid_d;
            rd_bank_q   <= rd_bank_d;
            swap_q      <= swap_d;
            rel_bank_q  <= rel_bank_d;
            rel_tgl_q   <= rel_tgl_d;
        end
    end

`ifdef FRAME_REPEAT_CNT_EN
    logic [7:0] rep_q, rep_d;

    // Count Vsyncs that re-show the same frame; a new frame clears the count
    always_comb begin
        rep_d = rep_q;
        if (take_frame)                                   rep_d = 8'd0;
        else if (vs_rise && rd_valid_q && rep_q != 8'hFF) rep_d = rep_q + 8'd1;
    end

    // Repeat counter register
    always_ff @(posedge GCK or posedge rst) begin
        if (rst) rep_q <= 8'd0;
        else     rep_q <= rep_d;
    end

    assign bus.repeat_cnt = rep_q;
`else
    assign bus.repeat_cnt = 8'd0;
`endif

    assign bus.wr_ready    = wr_ready;
    assign bus.wr_addr     = {wr_bank_q, wr_idx_q};
    assign bus.wr_overflow = wr_ovf_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_bank     = rd_bank_q;
    assign bus.frame_swap  = swap_q;
endmodule
